note_history: RTL and testbench



---
 rtl/note_pkg.sv | 15 +
 rtl/note_hist_bank.sv | 48 ++++
 rtl/note_history.sv | 164 ++++++++++++++++
 tb/tb_note_history.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared encodings for the note history buffer: command opcodes and scan FSM states.
// Used by both builds (with and without NOTE_HISTORY_HIST_EN).
package note_pkg;

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_COUNT = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

endpackage

// File: rtl/note_hist_bank.sv
// Running per-value occurrence counters for the held notes; one counter per note value.
// Only instantiated by note_history when NOTE_HISTORY_HIST_EN is defined.
module note_hist_bank #(
    parameter int NOTE_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              inc_en_i,
    input  logic [NOTE_W-1:0] inc_val_i,
    input  logic              dec_en_i,
    input  logic [NOTE_W-1:0] dec_val_i,
    input  logic [NOTE_W-1:0] key_i,
    output logic [CNT_W-1:0]  cnt_o
);

    localparam int NVAL = 2 ** NOTE_W;

    logic [CNT_W-1:0] cnt_q [NVAL];
    logic [CNT_W-1:0] cnt_d [NVAL];

    // A push that evicts an equal value leaves the counter unchanged.
    always_comb begin
        for (int v = 0; v < NVAL; v++) begin
            cnt_d[v] = cnt_q[v];
            if (clr_i) begin
                cnt_d[v] = '0;
            end else if ((inc_en_i && inc_val_i == NOTE_W'(v)) &&
                         !(dec_en_i && dec_val_i == NOTE_W'(v))) begin
                cnt_d[v] = cnt_q[v] + CNT_W'(1);
            end else if ((dec_en_i && dec_val_i == NOTE_W'(v)) &&
                         !(inc_en_i && inc_val_i == NOTE_W'(v))) begin
                cnt_d[v] = cnt_q[v] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NVAL; v++) begin
            if (reset) cnt_q[v] <= '0;
            else       cnt_q[v] <= cnt_d[v];
        end
    end

    assign cnt_o = cnt_q[key_i];

endmodule

// File: rtl/note_history.sv
// Ring-buffer note history with fill level, indexed READ and value COUNT via a busy handshake.
// NOTE_HISTORY_HIST_EN selects single-cycle COUNT from running counters instead of the scan FSM.
module note_history
    import note_pkg::*;
#(
    parameter  int NOTE_W = 3,
    parameter  int DEPTH  = 128,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [1:0]        op,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [IDX_W-1:0]  query,
    output logic [NOTE_W-1:0] note_out,
    output logic              miss,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  level,
    output logic              busy,
    output logic              done
);

    logic [NOTE_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  level_q;
    logic [CNT_W-1:0]  count_q;
    logic [NOTE_W-1:0] note_out_q;
    logic              miss_q;
    logic              done_q;

    logic              accept;
    logic              full;
    logic [IDX_W-1:0]  base;
    logic [IDX_W-1:0]  rd_slot;
    logic [NOTE_W-1:0] key;
    logic              count_upd;
    logic [CNT_W-1:0]  count_d;

    assign accept  = op_valid && !busy;
    assign full    = (level_q == CNT_W'(DEPTH));
    // Oldest held entry; level==DEPTH truncates to 0, which is correct modulo DEPTH.
    assign base    = wr_ptr_q - level_q[IDX_W-1:0];
    assign rd_slot = base + query;
    assign key     = NOTE_W'(query);

    always_ff @(posedge clk) begin
        if (accept && op == OP_PUSH) mem_q[wr_ptr_q] <= note_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            level_q    <= '0;
            count_q    <= '0;
            note_out_q <= '0;
            miss_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= count_upd;
            if (count_upd) count_q <= count_d;
            if (accept) begin
                case (op)
                    OP_PUSH: begin
                        wr_ptr_q <= wr_ptr_q + IDX_W'(1);
                        if (!full) level_q <= level_q + CNT_W'(1);
                    end
                    OP_READ: begin
                        if (CNT_W'(query) < level_q) begin
                            note_out_q <= mem_q[rd_slot];
                            miss_q     <= 1'b0;
                        end else begin
                            note_out_q <= '0;
                            miss_q     <= 1'b1;
                        end
                    end
                    OP_CLEAR: begin
                        wr_ptr_q <= '0;
                        level_q  <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef NOTE_HISTORY_HIST_EN
    logic [CNT_W-1:0] hist_cnt;

    note_hist_bank #(
        .NOTE_W (NOTE_W),
        .CNT_W  (CNT_W)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (accept && op == OP_CLEAR),
        .inc_en_i  (accept && op == OP_PUSH),
        .inc_val_i (note_in),
        .dec_en_i  (accept && op == OP_PUSH && full),
        .dec_val_i (mem_q[wr_ptr_q]),
        .key_i     (key),
        .cnt_o     (hist_cnt)
    );

    assign busy      = 1'b0;
    assign count_upd = accept && op == OP_COUNT;
    assign count_d   = hist_cnt;
`else
    scan_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [NOTE_W-1:0] key_q;
    logic              scan_hit;
    logic              scan_last;

    assign scan_hit  = (level_q != '0) && (mem_q[base + idx_q] == key_q);
    assign scan_last = (level_q == '0) || (CNT_W'(idx_q) == level_q - CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        count_upd = 1'b0;
        count_d   = acc_q + CNT_W'(scan_hit);
        case (state_q)
            ST_IDLE: begin
                if (accept && op == OP_COUNT) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_SCAN: begin
                if (scan_last) begin
                    state_d   = ST_IDLE;
                    count_upd = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    acc_d = count_d;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
        idx_q <= idx_d;
        acc_q <= acc_d;
        if (accept && op == OP_COUNT) key_q <= key;
    end

    assign busy = (state_q == ST_SCAN);
`endif

    assign note_out = note_out_q;
    assign miss     = miss_q;
    assign count    = count_q;
    assign level    = level_q;
    assign done     = done_q;

endmodule

// File: tb/tb_note_history.sv
// Directed bench for note_history: an 8-deep and a 4-deep instance driven from one vector table.
// Honours NOTE_HISTORY_HIST_EN for the expected busy duration of COUNT.
module tb_note_history;
    import note_pkg::*;

`ifdef NOTE_HISTORY_HIST_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] op;
    logic [2:0] note_in;
    logic       ov8, ov4;
    logic [2:0] q8;
    logic [1:0] q4;

    logic [2:0] no8, no4;
    logic       m8, m4, busy8, busy4, done8, done4;
    logic [3:0] cnt8, lvl8;
    logic [2:0] cnt4, lvl4;

    note_history #(.NOTE_W(3), .DEPTH(8)) dut8 (
        .clk(clk), .reset(reset), .op_valid(ov8), .op(op), .note_in(note_in),
        .query(q8), .note_out(no8), .miss(m8), .count(cnt8), .level(lvl8),
        .busy(busy8), .done(done8)
    );

    note_history #(.NOTE_W(3), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .op_valid(ov4), .op(op), .note_in(note_in),
        .query(q4), .note_out(no4), .miss(m4), .count(cnt4), .level(lvl4),
        .busy(busy4), .done(done4)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         sel;   // 0: DEPTH=8 instance, 1: DEPTH=4 instance
        logic [1:0] op;
        int         note;
        int         q;
        int         eno;
        int         emiss;
        int         ecnt;
        int         elvl;
        int         enb;   // busy cycles for COUNT in the scan build
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int g_no(input int s);   return (s == 1) ? int'(no4)   : int'(no8);   endfunction
    function automatic int g_miss(input int s); return (s == 1) ? int'(m4)    : int'(m8);    endfunction
    function automatic int g_cnt(input int s);  return (s == 1) ? int'(cnt4)  : int'(cnt8);  endfunction
    function automatic int g_lvl(input int s);  return (s == 1) ? int'(lvl4)  : int'(lvl8);  endfunction
    function automatic int g_busy(input int s); return (s == 1) ? int'(busy4) : int'(busy8); endfunction
    function automatic int g_done(input int s); return (s == 1) ? int'(done4) : int'(done8); endfunction

    // Present one command for one cycle; returns at the negedge after acceptance.
    task automatic cmd(input int s, input logic [1:0] o, input int n, input int q);
        @(negedge clk);
        op      = o;
        note_in = 3'(n);
        q8      = 3'(q);
        q4      = 2'(q);
        if (s == 1) ov4 = 1'b1;
        else        ov8 = 1'b1;
        @(negedge clk);
        ov4 = 1'b0;
        ov8 = 1'b0;
    endtask

    // Waits (bounded) for done, counting busy cycles seen on the way.
    task automatic wait_done(input int s, input string nm, output int nb);
        bit seen;
        nb   = 0;
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (g_done(s) == 1) begin
                seen = 1'b1;
                break;
            end
            if (g_busy(s) == 1) nb++;
            @(negedge clk);
        end
        chk({nm, "_done_seen"}, int'(seen), 1);
    endtask

    task automatic add(input int s, input logic [1:0] o, input int n, input int q,
                       input int eno, input int em, input int ec, input int el, input int enb);
        vec_t v;
        v = '{s, o, n, q, eno, em, ec, el, enb};
        vecs.push_back(v);
    endtask

    initial begin
        int nb;
        reset = 1'b1;
        op = OP_PUSH; note_in = '0; q8 = '0; q4 = '0; ov8 = 1'b0; ov4 = 1'b0;

        //   sel op        note q  no miss cnt lvl nb
        add(0, OP_READ,  0, 0, 0, 1, 0, 0, 1);
        add(0, OP_COUNT, 0, 0, 0, 1, 0, 0, 1);
        add(0, OP_PUSH,  5, 0, 0, 1, 0, 1, 0);
        add(0, OP_PUSH,  3, 0, 0, 1, 0, 2, 0);
        add(0, OP_PUSH,  5, 0, 0, 1, 0, 3, 0);
        add(0, OP_COUNT, 0, 5, 0, 1, 2, 3, 3);
        add(0, OP_READ,  0, 2, 5, 0, 2, 3, 0);
        add(0, OP_READ,  0, 3, 0, 1, 2, 3, 0);
        add(0, OP_READ,  0, 1, 3, 0, 2, 3, 0);
        add(1, OP_PUSH,  1, 0, 0, 0, 0, 1, 0);
        add(1, OP_PUSH,  2, 0, 0, 0, 0, 2, 0);
        add(1, OP_PUSH,  3, 0, 0, 0, 0, 3, 0);
        add(1, OP_PUSH,  4, 0, 0, 0, 0, 4, 0);
        add(1, OP_PUSH,  6, 0, 0, 0, 0, 4, 0);
        add(1, OP_READ,  0, 0, 2, 0, 0, 4, 0);
        add(1, OP_READ,  0, 3, 6, 0, 0, 4, 0);
        add(1, OP_COUNT, 0, 1, 6, 0, 0, 4, 4);
        add(1, OP_COUNT, 0, 2, 6, 0, 1, 4, 4);
        add(0, OP_CLEAR, 0, 0, 3, 0, 2, 0, 0);
        for (int i = 1; i <= 8; i++) add(0, OP_PUSH, 7, 0, 3, 0, 2, i, 0);
        add(0, OP_PUSH,  7, 0, 3, 0, 2, 8, 0);
        add(0, OP_COUNT, 0, 7, 3, 0, 8, 8, 8);
        add(0, OP_READ,  0, 7, 7, 0, 8, 8, 0);
        add(0, OP_CLEAR, 0, 0, 7, 0, 8, 0, 0);
        add(0, OP_COUNT, 0, 7, 7, 0, 0, 0, 1);
        add(0, OP_READ,  0, 0, 0, 1, 0, 0, 0);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_note_out", int'(no8), 0);
        chk("rst_miss", int'(m8), 0);
        chk("rst_count", int'(cnt8), 0);
        chk("rst_level", int'(lvl8), 0);
        chk("rst_busy", int'(busy8), 0);
        chk("rst_done", int'(done8), 0);
        chk("rst_level4", int'(lvl4), 0);

        foreach (vecs[k]) begin
            vec_t v;
            string tag;
            v   = vecs[k];
            tag = $sformatf("v%0d", k);
            cmd(v.sel, v.op, v.note, v.q);
            if (v.op == OP_COUNT) begin
                wait_done(v.sel, tag, nb);
                chk({tag, "_busy_cycles"}, nb, HIST ? 0 : v.enb);
            end else begin
                chk({tag, "_no_done"}, g_done(v.sel), 0);
            end
            chk({tag, "_note_out"}, g_no(v.sel), v.eno);
            chk({tag, "_miss"}, g_miss(v.sel), v.emiss);
            chk({tag, "_count"}, g_cnt(v.sel), v.ecnt);
            chk({tag, "_level"}, g_lvl(v.sel), v.elvl);
        end

        // Commands presented while busy are dropped; a command in the done cycle is accepted.
        cmd(0, OP_PUSH, 5, 0);
        cmd(0, OP_PUSH, 3, 0);
        cmd(0, OP_PUSH, 5, 0);
        cmd(0, OP_PUSH, 2, 0);
        @(negedge clk);
        op = OP_COUNT; q8 = 3'd5; ov8 = 1'b1;
        @(negedge clk);
        ov8 = 1'b0;
`ifndef NOTE_HISTORY_HIST_EN
        op = OP_PUSH; note_in = 3'd7; ov8 = 1'b1;
        @(negedge clk);
        op = OP_READ; q8 = 3'd0;
        @(negedge clk);
        ov8 = 1'b0;
`endif
        wait_done(0, "busy_drop", nb);
        chk("busy_drop_count", int'(cnt8), 2);
        chk("busy_drop_level", int'(lvl8), 4);
        chk("busy_drop_note_out", int'(no8), 0);
        chk("busy_drop_miss", int'(m8), 1);
        op = OP_READ; q8 = 3'd1; ov8 = 1'b1;
        @(negedge clk);
        ov8 = 1'b0;
        chk("done_cycle_read", int'(no8), 3);
        chk("done_cycle_miss", int'(m8), 0);
        chk("done_single_pulse", int'(done8), 0);

        // Reset asserted while a scan is in progress.
        cmd(0, OP_COUNT, 0, 3);
`ifndef NOTE_HISTORY_HIST_EN
        chk("midscan_busy", int'(busy8), 1);
        chk("midscan_no_done", int'(done8), 0);
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_done", int'(done8), 0);
        chk("abort_busy", int'(busy8), 0);
        chk("abort_count", int'(cnt8), 0);
        chk("abort_level", int'(lvl8), 0);
        @(negedge clk);
        chk("abort_done_later", int'(done8), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
